// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the processor stage sequencer
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        WAIT_MFC = 2'd2,
        ERR      = 2'd3
    } seq_state_t;

    localparam int STAGE_FETCH = 1;
    localparam int STAGE_W     = 3;

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - loadable down-counter with zero flag for fetch hold and MFC timeout
module wait_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - multi-cycle stage sequencer with fetch hold, MFC wait and step mode
module stage_sequencer
    import proc_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int MEM_STAGE   = 4,
    parameter int FETCH_WAIT  = 0,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic               Clock,
    input  logic               Reset_L,
    input  logic               Run,
    input  logic               Step_Mode,
    input  logic               Step,
    input  logic               Mem_Access,
    input  logic               RAM1_MFC,
    input  logic               Clear_Err,
    output logic [STAGE_W-1:0] Stage,
    output logic [7:0]         Stage_OneHot,
    output logic               Stage_Advance,
    output logic               Mem_Req,
    output logic               Stall,
    output logic               Instr_Done,
    output logic               Timeout_Err,
    output logic [31:0]        Cycle_Count,
    output logic [31:0]        Instr_Count
);

    // One extra bit so that stage index 8 is representable internally.
    typedef logic [STAGE_W:0] stage_t;

    localparam stage_t     FIRST_STAGE = stage_t'(STAGE_FETCH);
    localparam stage_t     LAST_STAGE  = stage_t'(NUM_STAGES);
    localparam stage_t     PRE_MEM     = stage_t'(MEM_STAGE - 1);
    localparam stage_t     POST_MEM    = stage_t'(MEM_STAGE + 1);
    localparam logic [7:0] FETCH_LOAD  = 8'(FETCH_WAIT);
    localparam logic [7:0] MFC_LOAD    = 8'(MFC_TIMEOUT - 1);

    seq_state_t  state_q, state_d;
    stage_t      stage_q, stage_d;
    logic        arm_q, arm_d;
    logic        err_q, err_d;
    logic [31:0] ccnt_q, ccnt_d;
    logic [31:0] icnt_q, icnt_d;

    logic        tmr_load;
    logic [7:0]  tmr_val;
    logic        tmr_dec;
    logic        tmr_zero;
    logic        advance;
    logic        go;
    logic        active;

    wait_timer #(.W(8)) u_wait_timer (
        .clk_i      (Clock),
        .rst_ni     (Reset_L),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        arm_d    = arm_q;
        err_d    = err_q;
        ccnt_d   = ccnt_q;
        icnt_d   = icnt_q;
        tmr_load = 1'b0;
        tmr_val  = FETCH_LOAD;
        tmr_dec  = 1'b0;
        advance  = 1'b0;
        go       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Run && (!Step_Mode || arm_q)) begin
                    go       = 1'b1;
                    state_d  = RUN;
                    stage_d  = FIRST_STAGE;
                    tmr_load = 1'b1;
                end
            end
            RUN: begin
                ccnt_d = ccnt_q + 32'd1;
                if ((stage_q == FIRST_STAGE) && !tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (stage_q == LAST_STAGE) begin
                        icnt_d = icnt_q + 32'd1;
                        if (Run && !Step_Mode && !err_q) begin
                            stage_d  = FIRST_STAGE;
                            tmr_load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            stage_d = '0;
                        end
                    end else if ((stage_q == PRE_MEM) && Mem_Access) begin
                        state_d  = WAIT_MFC;
                        stage_d  = stage_q + stage_t'(1);
                        tmr_load = 1'b1;
                        tmr_val  = MFC_LOAD;
                    end else begin
                        stage_d = stage_q + stage_t'(1);
                    end
                end
            end
            WAIT_MFC: begin
                ccnt_d = ccnt_q + 32'd1;
                // MFC is checked before the timeout so a late MFC still completes.
                if (RAM1_MFC) begin
                    advance = 1'b1;
                    state_d = RUN;
                    stage_d = POST_MEM;
                end else if (tmr_zero) begin
                    state_d = ERR;
                    stage_d = '0;
                    err_d   = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ERR: begin
                if (Clear_Err) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                stage_d = '0;
            end
        endcase

        if (go) begin
            arm_d = 1'b0;
        end else if (Step && ((state_q == IDLE) || (state_q == RUN))) begin
            arm_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            stage_q <= '0;
            arm_q   <= 1'b0;
            err_q   <= 1'b0;
            ccnt_q  <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            arm_q   <= arm_d;
            err_q   <= err_d;
            ccnt_q  <= ccnt_d;
            icnt_q  <= icnt_d;
        end
    end

    assign active = (state_q == RUN) || (state_q == WAIT_MFC);

    always_comb begin
        Stage        = '0;
        Stage_OneHot = '0;
        if (active) begin
            Stage        = stage_q[STAGE_W-1:0];
            Stage_OneHot = 8'd1 << (stage_q - stage_t'(1));
        end
    end

    assign Stage_Advance = advance;
    assign Mem_Req       = (state_q == WAIT_MFC);
    assign Stall         = ((state_q == RUN) && (stage_q == FIRST_STAGE) && !tmr_zero)
                         || (state_q == WAIT_MFC);
    assign Instr_Done    = (state_q == RUN) && (stage_q == LAST_STAGE);
    assign Timeout_Err   = err_q;
    assign Cycle_Count   = ccnt_q;
    assign Instr_Count   = icnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench for stage_sequencer
module tb_stage_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic run = 1'b0, run_fw = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic mem_access = 1'b0, mfc = 1'b0, clear_err = 1'b0;

    logic [2:0]  stg0, stg1;
    logic [7:0]  oh0, oh1;
    logic        adv0, adv1, mreq0, mreq1, stall0, stall1, done0, done1, terr0, terr1;
    logic [31:0] cc0, cc1, ic0, ic1;

    always #5 clk = ~clk;

    stage_sequencer u_dut (
        .Clock(clk), .Reset_L(rst_n), .Run(run), .Step_Mode(step_mode), .Step(step),
        .Mem_Access(mem_access), .RAM1_MFC(mfc), .Clear_Err(clear_err),
        .Stage(stg0), .Stage_OneHot(oh0), .Stage_Advance(adv0), .Mem_Req(mreq0),
        .Stall(stall0), .Instr_Done(done0), .Timeout_Err(terr0),
        .Cycle_Count(cc0), .Instr_Count(ic0)
    );

    stage_sequencer #(.FETCH_WAIT(2)) u_fw (
        .Clock(clk), .Reset_L(rst_n), .Run(run_fw), .Step_Mode(step_mode), .Step(step),
        .Mem_Access(mem_access), .RAM1_MFC(mfc), .Clear_Err(clear_err),
        .Stage(stg1), .Stage_OneHot(oh1), .Stage_Advance(adv1), .Mem_Req(mreq1),
        .Stall(stall1), .Instr_Done(done1), .Timeout_Err(terr1),
        .Cycle_Count(cc1), .Instr_Count(ic1)
    );

    typedef struct {
        int          lat;
        int          stl;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   lat[2];
    int   stl[2];

    int fw_stage[9] = '{1, 1, 1, 2, 3, 4, 4, 4, 5};
    int fw_stall[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int l, input int s, input logic [31:0] i, input logic [31:0] c);
        exp_t e;
        e.lat = l; e.stl = s; e.ic = i; e.cc = c;
        return e;
    endfunction

    // Monitor: accumulates latency/stall per instruction and pops on Instr_Done.
    always @(negedge clk) begin
        logic [2:0]  s;
        logic        st, dn;
        logic [31:0] ic, cc;
        exp_t        e;
        for (int k = 0; k < 2; k++) begin
            s  = (k == 0) ? stg0 : stg1;
            st = (k == 0) ? stall0 : stall1;
            dn = (k == 0) ? done0 : done1;
            ic = (k == 0) ? ic0 : ic1;
            cc = (k == 0) ? cc0 : cc1;
            if (!rst_n || s == 3'd0) begin
                lat[k] = 0;
                stl[k] = 0;
            end else begin
                lat[k]++;
                if (st) stl[k]++;
                if (dn) begin
                    if (((k == 0) ? q0.size() : q1.size()) == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected_done dut=%0d at %0t", k, $time);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        chk($sformatf("sb_latency_dut%0d", k), lat[k], e.lat);
                        chk($sformatf("sb_stall_dut%0d", k), stl[k], e.stl);
                        chk($sformatf("sb_icount_dut%0d", k), ic, e.ic);
                        chk($sformatf("sb_ccount_dut%0d", k), cc, e.cc);
                    end
                    lat[k] = 0;
                    stl[k] = 0;
                end
            end
        end
    end

    task automatic do_reset;
        rst_n = 1'b0;
        run = 0; run_fw = 0; step_mode = 0; step = 0; mem_access = 0; mfc = 0; clear_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_stage", stg0, 0);
        chk("rst_onehot", oh0, 0);
        chk("rst_adv", adv0, 0);
        chk("rst_memreq", mreq0, 0);
        chk("rst_stall", stall0, 0);
        chk("rst_done", done0, 0);
        chk("rst_terr", terr0, 0);
        chk("rst_ccount", cc0, 0);
        chk("rst_icount", ic0, 0);
        do_reset();
        chk("idle_no_run", stg0, 0);

        // Free-run, three back-to-back instructions
        for (int i = 0; i < 3; i++) q0.push_back(mk(5, 0, i, 5 * i + 4));
        run = 1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk($sformatf("fr_stage_c%0d", c + 1), stg0, (c % 5) + 1);
            chk($sformatf("fr_onehot_c%0d", c + 1), oh0, 32'd1 << (c % 5));
            if (c == 14) run = 0;
        end
        @(negedge clk);
        chk("fr_idle", stg0, 0);
        chk("fr_icount", ic0, 3);
        chk("fr_ccount", cc0, 15);

        // Fetch hold of 2 and MFC in the third memory-stage cycle
        do_reset();
        mem_access = 1;
        run_fw = 1;
        q1.push_back(mk(9, 5, 0, 8));
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) run_fw = 0;
            chk($sformatf("fw_stage_c%0d", c), stg1, fw_stage[c-1]);
            chk($sformatf("fw_stall_c%0d", c), stall1, fw_stall[c-1]);
            if (c == 8) begin
                mfc = 1;
                #1 chk("fw_mfc_advance", adv1, 1);
            end
            if (c == 9) mfc = 0;
        end
        repeat (2) @(negedge clk);
        chk("fw_idle", stg1, 0);
        chk("fw_icount", ic1, 1);

        // MFC never arrives: timeout after 15 wait cycles
        do_reset();
        mem_access = 1;
        run = 1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) run = 0;
            if (c == 4) chk("to_memreq_first", mreq0, 1);
            if (c == 18) chk("to_stage_last_wait", stg0, 4);
        end
        @(negedge clk);
        chk("to_err", terr0, 1);
        chk("to_stage0", stg0, 0);
        chk("to_memreq0", mreq0, 0);
        chk("to_stall0", stall0, 0);
        chk("to_ccount", cc0, 18);
        repeat (3) @(negedge clk);
        chk("to_ccount_frozen", cc0, 18);
        chk("to_err_sticky", terr0, 1);
        clear_err = 1;
        @(negedge clk);
        clear_err = 0;
        chk("to_cleared", terr0, 0);
        mem_access = 0;
        run = 1;
        q0.push_back(mk(5, 0, 0, 22));
        @(negedge clk);
        run = 0;
        chk("to_restart_stage", stg0, 1);
        repeat (6) @(negedge clk);

        // MFC on the same cycle the timeout is reached
        do_reset();
        mem_access = 1;
        run = 1;
        q0.push_back(mk(19, 15, 0, 18));
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) run = 0;
            if (c == 18) mfc = 1;
        end
        @(negedge clk);
        mfc = 0;
        chk("mfcwin_stage", stg0, 5);
        chk("mfcwin_noerr", terr0, 0);
        repeat (2) @(negedge clk);
        chk("mfcwin_idle", stg0, 0);

        // Step mode: extra pulses while armed are dropped
        do_reset();
        step_mode = 1;
        run = 1;
        repeat (2) @(negedge clk);
        chk("step_wait", stg0, 0);
        q0.push_back(mk(5, 0, 0, 4));
        q0.push_back(mk(5, 0, 1, 9));
        for (int n = 0; n < 20; n++) begin
            step = (n == 0 || n == 3 || n == 5);
            if (n == 0 || n == 1 || n == 7 || n >= 13) chk($sformatf("step_idle_n%0d", n), stg0, 0);
            if (n == 2 || n == 8) chk($sformatf("step_start_n%0d", n), stg0, 1);
            @(negedge clk);
        end
        step_mode = 0;
        run = 0;
        chk("step_icount", ic0, 2);
        chk("step_ccount", cc0, 10);

        // Async reset during WAIT_MFC
        do_reset();
        mem_access = 1;
        run = 1;
        repeat (5) @(negedge clk);
        chk("ar_stage4", stg0, 4);
        chk("ar_memreq", mreq0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stage", stg0, 0);
        chk("ar_onehot", oh0, 0);
        chk("ar_memreq0", mreq0, 0);
        chk("ar_stall0", stall0, 0);
        chk("ar_ccount", cc0, 0);
        mem_access = 0;
        q0.push_back(mk(5, 0, 0, 4));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_restart", stg0, 1);
        run = 0;
        repeat (6) @(negedge clk);

        // Cycle counter wrap
        do_reset();
        force u_dut.ccnt_q = 32'hFFFF_FFFE;
        #1 release u_dut.ccnt_q;
        run = 1;
        q0.push_back(mk(5, 0, 0, 32'd2));
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) run = 0;
            if (c == 1) chk("wrap_c1", cc0, 32'hFFFF_FFFE);
            if (c == 3) chk("wrap_c3", cc0, 32'd0);
            if (c == 4) chk("wrap_c4", cc0, 32'd1);
        end
        repeat (3) @(negedge clk);

        chk("sb_drain_dut0", q0.size(), 0);
        chk("sb_drain_dut1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multi-cycle stage sequencer for the processor datapath. It steps an instruction through NUM_STAGES stages and stretches the fetch stage for ROM latency. It stalls the memory stage on a RAM MFC handshake with a timeout, and supports free-run and single-step modes. It also exposes per-stage strobes plus cycle and instruction counters that feed the control signal generator and the display mux.

## Interface
- NUM_STAGES, 5, stage count, legal 3..8; stage indices 1..NUM_STAGES.
- MEM_STAGE, 4, stage index that performs the RAM access; must be in 2..NUM_STAGES-1.
- FETCH_WAIT, 0, extra cycles stage 1 is held for ROM latency; legal 0..7.
- MFC_TIMEOUT, 15, maximum wait cycles for RAM1_MFC before error; legal 1..255.
- Clock  in  1  single clock; everything is rising-edge.
- Reset_L  in  1  asynchronous, active-low reset.
- Run  in  1  level; high permits instructions to start.
- Step_Mode  in  1  level; high means one instruction per Step pulse.
- Step  in  1  one-cycle pulse; arms one instruction in step mode.
- Mem_Access  in  1  current instruction uses RAM; sampled on entry to MEM_STAGE.
- RAM1_MFC  in  1  memory function complete.
- Clear_Err  in  1  clears the timeout error and returns to IDLE.
- Stage  out  3  current stage index; 0 when idle or in error.
- Stage_OneHot  out  8  bit k-1 high in stage k; all zero when idle or in error.
- Stage_Advance  out  1  high in the last cycle of a stage.
- Mem_Req  out  1  high throughout the memory wait.
- Stall  out  1  high while a stage is held by fetch wait or MFC wait.
- Instr_Done  out  1  one-cycle pulse in the final cycle of stage NUM_STAGES.
- Timeout_Err  out  1  sticky; set on MFC timeout.
- Cycle_Count  out  32  cycles spent in RUN or WAIT_MFC.
- Instr_Count  out  32  completed instructions.

## Operation
- FSM states: IDLE, RUN, WAIT_MFC, ERR.
- IDLE → RUN with Stage=1:
  - when Run=1 and Step_Mode=0, or
  - when Run=1, Step_Mode=1, and a step is armed.
- Step arming: a Step pulse while in IDLE or RUN sets an arm flag. The flag is consumed on the IDLE→RUN transition. Further pulses while armed are ignored (no queueing beyond one).
- Stage 1: held for FETCH_WAIT extra cycles via the wait counter, with Stall=1. Then it advances.
- Other stages advance every cycle, except MEM_STAGE.
- Entering MEM_STAGE:
  - with Mem_Access=1: go to WAIT_MFC, Mem_Req=1, Stall=1.
  - with Mem_Access=0: advance like any other stage.
- WAIT_MFC, RAM1_MFC=1: Stage_Advance=1 and go to MEM_STAGE+1. MFC in the first wait cycle is accepted, giving a 1-cycle memory stage.
- WAIT_MFC timeout: the wait counter reaches MFC_TIMEOUT without MFC → ERR, Timeout_Err=1, Mem_Req=0.
- Stage NUM_STAGES: Instr_Done=1 and Instr_Count increments. Then:
  - Stage=1, if Run=1, Step_Mode=0, and Timeout_Err=0;
  - otherwise IDLE.
- Run dropping mid-instruction does not abort; the instruction completes first.
- ERR: outputs idle, counters frozen. Clear_Err=1 → IDLE and clears Timeout_Err. ERR is left only via Clear_Err or reset.
- Counters wrap modulo 2^32 with no saturation.

## Timing
- Reset (async assert; deassert synchronised by the parent):
  - state IDLE, Stage=0, Stage_OneHot=0;
  - all strobes 0;
  - Timeout_Err=0;
  - counters 0;
  - arm flag 0.
- All outputs are registered or decoded from registered state only; there are no combinational input→output paths.
- RAM1_MFC is the exception: it may be used combinationally for Stage_Advance in WAIT_MFC.
- Instruction latency is NUM_STAGES + FETCH_WAIT + W cycles, where W is the number of MFC wait cycles; W=0 when Mem_Access=0.
- Back-to-back free-run instructions have no idle bubble.
- First stage-1 cycle is the cycle after Run is sampled high in IDLE.
- Simultaneous events:
  - Clear_Err and reset: reset wins.
  - MFC in the same cycle the timeout is reached: MFC wins and there is no error.

## Structure
- Shared package proc_pkg holds:
  - the seq_state_t enum (IDLE/RUN/WAIT_MFC/ERR);
  - the STAGE_FETCH=1 localparam;
  - the STAGE_W=3 width constant.
- One natural sub-module is wait_timer, a loadable down-counter with a zero flag. It serves both the fetch hold and the MFC timeout.

## Test plan
- Defaults, Run=1, Mem_Access=0, 3 instructions:
  - Stage runs 1,2,3,4,5,1,… with no gaps;
  - Instr_Done pulses at cycles 5, 10, 15;
  - Instr_Count=3, Cycle_Count=15.
- FETCH_WAIT=2, Mem_Access=1, MFC arrives 3 cycles after entering stage 4:
  - Stall high for 2 cycles in stage 1 and 3 cycles in stage 4;
  - instruction latency is 5+2+2=9.
- MFC never arrives, MFC_TIMEOUT=15:
  - ERR entered after 15 wait cycles, Timeout_Err=1, Stage=0, counters frozen;
  - Clear_Err → IDLE.
- Step_Mode=1, two Step pulses in the same instruction: exactly one further instruction runs, then IDLE, Instr_Count=+2 total.
- Reset_L low while in WAIT_MFC at stage 4: all outputs are immediately at reset values; after release with Run=1, execution restarts at stage 1.
- Cycle_Count preloaded via force to 32'hFFFF_FFFE, 3 cycles run: the counter wraps to 1.
